// File: rtl/afifo_rd_ctrl_if.sv
// rtl/afifo_rd_ctrl_if.sv - read-side pointer bundle between consumer, write domain and controller
interface afifo_rd_ctrl_if #(
  parameter int AW = 4
);
  logic [AW:0]   wptr_gray;
  logic          rd_en;
  logic          rd_fire;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          empty;
  logic [AW:0]   rd_level;
  logic          ovf_err;

  modport slave (
    input  wptr_gray,
    input  rd_en,
    output rd_fire,
    output raddr,
    output rptr_gray,
    output empty,
    output rd_level,
    output ovf_err
  );

  modport master (
    output wptr_gray,
    output rd_en,
    input  rd_fire,
    input  raddr,
    input  rptr_gray,
    input  empty,
    input  rd_level,
    input  ovf_err
  );
endinterface

// File: rtl/afifo_rd_ctrl.sv
// rtl/afifo_rd_ctrl.sv - async FIFO read-side pointer, empty, level and overflow controller
module afifo_rd_ctrl #(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  afifo_rd_ctrl_if.slave  bus
);

  // 2^AW expressed on the pointer width; occupancy above this means the writer overran us
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("afifo_rd_ctrl: SYNC_STAGES must be in 2..4");
  end

  // sync_q[0] is the first flop after the clock crossing, sync_q[SYNC_STAGES-1] is wsync
  logic [SYNC_STAGES-1:0][AW:0] sync_q;
  logic [AW:0]                  wsync;
  logic [AW:0]                  wbin;

  logic [AW:0] rptr_bin_q, rptr_bin_d;
  logic [AW:0] rptr_gray_q, rptr_gray_d;
  logic [AW:0] level_q, level_d;
  logic        empty_q, empty_d;
  logic        ovf_q, ovf_d;
  logic        rd_fire;

  // Multi-flop synchronizer for the Gray write pointer crossing into the read clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.wptr_gray};
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= AW; i++) begin
      wbin[i] = ^(wsync >> i);
    end
  end

  // Pop acceptance depends only on the request and the registered empty flag
  assign rd_fire = bus.rd_en & ~empty_q;

  // Next-state pointer, flags and occupancy, all derived from the post-pop pointer
  always_comb begin
    rptr_bin_d  = rptr_bin_q + {{AW{1'b0}}, rd_fire};
    rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
    level_d     = wbin - rptr_bin_d;
    empty_d     = (rptr_gray_d == wsync);
    ovf_d       = ovf_q | (level_d > DEPTH);
  end

  // Read-domain state registers; ovf is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.rd_fire   = rd_fire;
  assign bus.raddr     = rptr_bin_q[AW-1:0];
  assign bus.rptr_gray = rptr_gray_q;
  assign bus.empty     = empty_q;
  assign bus.rd_level  = level_q;
  assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// tb/tb_afifo_rd_ctrl.sv - self-checking bench for afifo_rd_ctrl
module tb_afifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = 2 * DEPTH;

  logic clk;
  logic rst_n;

  afifo_rd_ctrl_if #(.AW(AW)) bus ();

  afifo_rd_ctrl #(.AW(AW), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: counts of words written/read, and the write count as seen after the crossing
  int wcnt;
  int m_rcnt;
  int m_wq[$];
  bit m_empty;
  int m_level;
  bit m_ovf;

  typedef struct {
    bit en;
    int w;
    bit fire;
    bit empty;
    int level;
    int raddr;
    int rgray;
    bit ovf;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [AW:0] g(int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rcnt  = 0;
    m_empty = 1'b1;
    m_level = 0;
    m_ovf   = 1'b0;
    m_wq.delete();
    for (int i = 0; i < SYNC; i++) m_wq.push_back(0);
  endtask

  // One clock edge of the reference: pop if non-empty, compare against the write count
  // that has made it through the synchronizer.
  task automatic model_edge();
    int vis;
    if (bus.rd_en && !m_empty) m_rcnt++;
    vis = m_wq.pop_front();
    m_wq.push_back(wcnt % PW);
    m_empty = ((m_rcnt % PW) == vis);
    m_level = (vis - (m_rcnt % PW) + PW) % PW;
    if (m_level > DEPTH) m_ovf = 1'b1;
  endtask

  task automatic check_model();
    chk("fire",  int'(bus.rd_fire),   int'(bus.rd_en && !m_empty));
    chk("empty", int'(bus.empty),     int'(m_empty));
    chk("level", int'(bus.rd_level),  m_level);
    chk("raddr", int'(bus.raddr),     m_rcnt % DEPTH);
    chk("rgray", int'(bus.rptr_gray), int'(g(m_rcnt)));
    chk("ovf",   int'(bus.ovf_err),   int'(m_ovf));
  endtask

  task automatic apply(bit en, int w);
    bus.rd_en     = en;
    wcnt          = w;
    bus.wptr_gray = g(w);
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(bit en, int w);
    apply(en, w);
    tick();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_empty"}, int'(bus.empty),     1);
    chk({tag, "_rgray"}, int'(bus.rptr_gray), 0);
    chk({tag, "_raddr"}, int'(bus.raddr),     0);
    chk({tag, "_level"}, int'(bus.rd_level),  0);
    chk({tag, "_ovf"},   int'(bus.ovf_err),   0);
    chk({tag, "_fire"},  int'(bus.rd_fire),   0);
  endtask

  task automatic do_reset();
    bus.rd_en     = 1'b0;
    wcnt          = 0;
    bus.wptr_gray = '0;
    rst_n         = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pop_cnt;
    bit seen_wrap;
    logic [AW:0] prev_g;
    bit rd_bias;

    rst_n         = 1'b0;
    bus.rd_en     = 1'b0;
    bus.wptr_gray = '0;
    wcnt          = 0;
    model_reset();

    // {en, w | fire, empty, level, raddr, rptr_gray, ovf}: single write, pop on empty, short drain
    tbl[0]  = '{1'b0, 0, 1'b0, 1'b1, 0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 1, 1'b0, 1'b0, 1, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1, 1'b1, 1'b0, 1, 0, 0, 1'b0};
    tbl[6]  = '{1'b1, 2, 1'b0, 1'b1, 0, 1, 1, 1'b0};
    tbl[7]  = '{1'b1, 3, 1'b0, 1'b1, 0, 1, 1, 1'b0};
    tbl[8]  = '{1'b0, 3, 1'b0, 1'b1, 0, 1, 1, 1'b0};
    tbl[9]  = '{1'b0, 3, 1'b0, 1'b0, 1, 1, 1, 1'b0};
    tbl[10] = '{1'b1, 3, 1'b1, 1'b0, 2, 1, 1, 1'b0};
    tbl[11] = '{1'b1, 3, 1'b1, 1'b0, 1, 2, 3, 1'b0};
    tbl[12] = '{1'b1, 3, 1'b0, 1'b1, 0, 3, 2, 1'b0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      bus.rd_en     = tbl[i].en;
      wcnt          = tbl[i].w;
      bus.wptr_gray = g(tbl[i].w);
      @(negedge clk);
      chk($sformatf("tbl%0d_fire", i),  int'(bus.rd_fire),   int'(tbl[i].fire));
      chk($sformatf("tbl%0d_empty", i), int'(bus.empty),     int'(tbl[i].empty));
      chk($sformatf("tbl%0d_level", i), int'(bus.rd_level),  tbl[i].level);
      chk($sformatf("tbl%0d_raddr", i), int'(bus.raddr),     tbl[i].raddr);
      chk($sformatf("tbl%0d_rgray", i), int'(bus.rptr_gray), tbl[i].rgray);
      chk($sformatf("tbl%0d_ovf", i),   int'(bus.ovf_err),   int'(tbl[i].ovf));
      tick();
    end

    // Pop on empty for five cycles: nothing moves
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 0);
      chk("poe_fire",  int'(bus.rd_fire),   0);
      chk("poe_raddr", int'(bus.raddr),     0);
      chk("poe_rgray", int'(bus.rptr_gray), 0);
      chk("poe_level", int'(bus.rd_level),  0);
      tick();
    end

    // Fill to exactly full in one step, then drain with rd_en held
    do_reset();
    for (int i = 0; i < SYNC + 1; i++) cyc(1'b0, DEPTH);
    apply(1'b0, DEPTH);
    chk("fill_level", int'(bus.rd_level), DEPTH);
    chk("fill_ovf",   int'(bus.ovf_err),  0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, DEPTH);
      chk("drain_raddr", int'(bus.raddr),   i);
      chk("drain_fire",  int'(bus.rd_fire), 1);
      tick();
    end
    apply(1'b1, DEPTH);
    chk("drain_empty", int'(bus.empty),     1);
    chk("drain_rgray", int'(bus.rptr_gray), 5'b11000);
    chk("drain_level", int'(bus.rd_level),  0);
    chk("drain_fire0", int'(bus.rd_fire),   0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, DEPTH);
      chk("post_fire", int'(bus.rd_fire), 0);
      tick();
    end

    // Wrap: writer steps through bin 31 -> 0 -> 3 while the reader pops continuously
    seen_wrap = 1'b0;
    prev_g    = bus.rptr_gray;
    for (int i = 0; i < 40; i++) begin
      int w;
      w = (i < 19) ? (DEPTH + 1 + i) : (PW + 3);
      apply(1'b1, w);
      chk("wrap_level_le_depth", int'(bus.rd_level <= DEPTH), 1);
      chk("wrap_gray_1bit", int'($countones(prev_g ^ bus.rptr_gray) <= 1), 1);
      if (prev_g == 5'b10000 && bus.rptr_gray == 5'b00000) seen_wrap = 1'b1;
      prev_g = bus.rptr_gray;
      tick();
    end
    chk("wrap_seen", int'(seen_wrap), 1);
    apply(1'b0, PW + 3);
    chk("wrap_end_empty", int'(bus.empty), 1);
    chk("wrap_end_raddr", int'(bus.raddr), 3);
    tick();

    // Overflow: 17 words against an empty reader, then the writer pointer falls back
    do_reset();
    for (int i = 0; i < SYNC; i++) cyc(1'b0, DEPTH + 1);
    apply(1'b0, DEPTH + 1);
    chk("ovf_before", int'(bus.ovf_err), 0);
    tick();
    apply(1'b0, DEPTH + 1);
    chk("ovf_set", int'(bus.ovf_err), 1);
    tick();
    for (int i = 0; i < 5; i++) cyc(1'b0, 0);
    apply(1'b0, 0);
    chk("ovf_sticky", int'(bus.ovf_err), 1);
    tick();
    do_reset();

    // Randomized traffic against the reference, with one asynchronous reset mid-stream
    rd_bias = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int w;
      bit en;
      if (n % 400 == 0) rd_bias = ~rd_bias;
      if (n == 1500) begin
        bus.rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        bus.rd_en     = 1'b0;
        wcnt          = 0;
        bus.wptr_gray = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      w = wcnt;
      if ((w - m_rcnt) < DEPTH && $urandom_range(0, rd_bias ? 2 : 1) == 0) w = w + 1;
      en = rd_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc(en, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afifo_rd_ctrl.md
# afifo_rd_ctrl

Read-side pointer controller for an asynchronous FIFO. It sits downstream of the bin2gray encoder in the write domain. It synchronizes the Gray-coded write pointer into the read clock and decodes it to binary. From that it maintains the binary and Gray read pointers and produces the RAM read address, the empty flag, the occupancy and an overflow error. The Gray read pointer it outputs feeds the write domain's synchronizer.

## Interface
- AW, default 4: RAM address width; FIFO depth is 2^AW; pointers are AW+1 bits.
- SYNC_STAGES, default 2: flops in the write-pointer synchronizer chain; legal range 2..4.

- clk  in  1  read-domain clock; all state is on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low (assertion acts immediately, deassertion is sampled on clk).
- wptr_gray  in  AW+1  write pointer in Gray code, asynchronous to clk.
- rd_en  in  1  consumer pop request.
- rd_fire  out  1  combinational; equals rd_en & ~empty; marks an accepted pop.
- raddr  out  AW  RAM read address; equals rptr_bin[AW-1:0] (registered).
- rptr_gray  out  AW+1  registered Gray read pointer, sent to the write domain.
- empty  out  1  registered empty flag.
- rd_level  out  AW+1  registered occupancy, range 0..2^AW.
- ovf_err  out  1  sticky overflow flag.

## Operation
- Synchronizer:
  - SYNC_STAGES-flop shift chain on wptr_gray, all stages reset to 0.
  - wsync is the last stage.
  - wbin = gray2bin(wsync), combinational: bit i is the XOR of wsync bits AW..i.
- Read pointer:
  - rptr_bin is AW+1 bits and resets to 0.
  - rnext = rptr_bin + rd_fire, modulo 2^(AW+1); it wraps from 2^(AW+1)-1 to 0.
- At every clk edge:
  - rptr_bin <= rnext.
  - rptr_gray <= rnext ^ (rnext >> 1).
  - empty <= (bin2gray(rnext) == wsync).
  - rd_level <= (wbin - rnext) mod 2^(AW+1).
  - ovf_err <= ovf_err | ((wbin - rnext) mod 2^(AW+1) > 2^AW).
- Pop acceptance:
  - rd_en while empty=1 is ignored: rd_fire=0 and no pointer change.
  - rd_en while empty=0 advances the pointer exactly 1.
- rptr_gray changes at most one bit per cycle; this must hold across the wrap.
- Full is not generated here; it belongs to the write side.
- A pop and a newly visible write pointer in the same cycle are both reflected in the next empty and rd_level values, because both use rnext and wsync.
- Reset values of all outputs:
  - rptr_gray=0, raddr=0, rd_level=0, ovf_err=0.
  - empty=1.
  - Synchronizer stages = 0.
- Reset mid-operation clears all state at once, whatever rd_en is doing. After deassertion, empty stays 1 until wsync differs from 0.
- ovf_err is cleared only by reset.

## Timing
- wptr_gray change to wsync: SYNC_STAGES edges.
- wptr_gray change to empty/rd_level update: SYNC_STAGES+1 edges (3 for the default).
- rd_fire to raddr/rptr_gray/empty/rd_level update: the next edge (1 cycle).
- Data for raddr is read by the RAM in the cycle after the pop. The RAM is external and has a 1-cycle registered read.
- rd_fire must not feed back combinationally from any output. It depends only on rd_en and the registered empty.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0, then release it; separately, assert rst_n mid-stream without a clock edge.
  - Required: while rst_n=0, empty=1, rptr_gray=0, raddr=0, rd_level=0, ovf_err=0. The mid-stream assertion clears every output immediately.
- Single write:
  - Stimulus: AW=4; wptr_gray goes 00000 -> 00001 just after edge 0; no reads.
  - Required: empty=1 through edge 2, empty=0 and rd_level=1 after edge 3.
- Fill and drain:
  - Stimulus: wptr_gray = 11000 (bin 16); wait 3 edges; then hold rd_en=1.
  - Required: before the reads, rd_level=16 and ovf_err=0. raddr steps 0..15 on consecutive cycles. empty rises on the edge of the 16th pop, with rptr_gray=11000 and rd_level=0. rd_fire=0 thereafter.
- Pop on empty:
  - Stimulus: empty=1, rd_en=1 for 5 cycles.
  - Required: rd_fire=0 throughout; rptr_gray, raddr and rd_level unchanged.
- Wrap:
  - Stimulus: advance wptr_gray one step at a time through bin 31 -> 0 -> 3 while popping continuously.
  - Required: rptr_gray goes 10000 -> 00000 with a 1-bit change. rd_level never exceeds 16. There is no spurious empty=0 when the pointers are equal.
- Overflow:
  - Stimulus: with rptr_bin=0, drive wptr_gray = bin2gray(17) = 11001.
  - Required: ovf_err=1 after SYNC_STAGES+1 edges and stays 1 after wptr_gray returns to 00000, until rst_n=0.
